// File: rtl/neopix_chain.sv
// neopix_chain: WS2812-class serial LED driver streaming NUM_PIXELS pixels per
// frame onto a single-wire output, followed by a low latch period.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle frame request, sampled only in IDLE
//   pix_data   pixel word, transmitted MSB first
//   pix_valid  pix_data valid
//   pix_ready  pixel accepted when pix_valid && pix_ready
//   busy       frame in progress (start accepted .. done)
//   done       one-cycle pulse at the end of the latch period
//   underrun   one-cycle pulse when the frame aborts for lack of data
//   out        registered serial line to the strip
//
// Build option: define NEOPIX_GRB_ORDER_EN to send {R,G,B[,W]} words in
// G,R,B[,W] order (reordered when a word loads into the shift register).
module neopix_chain #(
  parameter int unsigned NUM_PIXELS     = 8,
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned T0H            = 4,
  parameter int unsigned T1H            = 12,
  parameter int unsigned TBIT           = 16,
  parameter int unsigned TRES           = 800
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun,
  output logic                      out
);

  localparam int unsigned CNT_W = $clog2(TBIT);
  localparam int unsigned BIT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam int unsigned PIX_W = $clog2(NUM_PIXELS + 1);
  localparam int unsigned LAT_W = $clog2(TRES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] TH0      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] TH1      = CNT_W'(T1H);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [PIX_W-1:0] PIX_N    = PIX_W'(NUM_PIXELS);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(TRES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FIRST, S_BIT_HI, S_BIT_LO, S_LATCH
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [BIT_W-1:0]          r_bit;
  logic [PIX_W-1:0]          r_req;
  logic [PIX_W-1:0]          r_sent;
  logic [LAT_W-1:0]          r_lat;
  logic [BITS_PER_PIXEL-1:0] r_shift;
  logic [BITS_PER_PIXEL-1:0] r_buf;
  logic                      r_buf_full;
  logic                      r_pix_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_underrun;
  logic                      r_out;

  logic                      w_in_bit;
  logic                      w_xfer;
  logic [CNT_W-1:0]          w_th;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_pix_end;
  logic                      w_finish;
  logic                      w_move;
  logic                      w_abort;
  logic                      w_buf_full_nxt;
  logic [PIX_W-1:0]          w_req_nxt;
  logic                      w_active_nxt;
  logic                      w_ready_nxt;

  // Byte order applied as a word enters the shift register.
  function automatic logic [BITS_PER_PIXEL-1:0] reorder(input logic [BITS_PER_PIXEL-1:0] d);
`ifdef NEOPIX_GRB_ORDER_EN
    logic [BITS_PER_PIXEL-1:0] r;
    r = d;
    r[BITS_PER_PIXEL-1 -: 8] = d[BITS_PER_PIXEL-9 -: 8];
    r[BITS_PER_PIXEL-9 -: 8] = d[BITS_PER_PIXEL-1 -: 8];
    return r;
`else
    return d;
`endif
  endfunction

  assign w_in_bit  = (r_state == S_BIT_HI) || (r_state == S_BIT_LO);
  assign w_xfer    = pix_valid && r_pix_ready;
  assign w_th      = r_shift[BITS_PER_PIXEL-1] ? TH1 : TH0;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_pix_end = w_in_bit && (r_cnt == CNT_LAST) && (r_bit == BIT_LAST);
  assign w_finish  = w_pix_end && (r_sent == PIX_N);
  assign w_move    = w_pix_end && !w_finish && r_buf_full;
  assign w_abort   = w_pix_end && !w_finish && !r_buf_full;

  // Next-cycle handshake view so pix_ready can be registered without lag.
  assign w_buf_full_nxt = (r_state == S_IDLE) ? 1'b0 :
                          ((r_buf_full && !w_move) || (w_xfer && (r_state != S_WAIT_FIRST)));
  assign w_req_nxt      = (r_state == S_IDLE) ? '0 : (r_req + PIX_W'(w_xfer));
  assign w_active_nxt   = ((r_state == S_IDLE) && start) || (r_state == S_WAIT_FIRST) ||
                          (w_in_bit && !w_finish && !w_abort);
  assign w_ready_nxt    = w_active_nxt && !w_buf_full_nxt && (w_req_nxt < PIX_N);

  // Frame sequencer, bit timing and prefetch buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_req       <= '0;
      r_sent      <= '0;
      r_lat       <= '0;
      r_shift     <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_out       <= 1'b0;
    end else begin
      r_pix_ready <= w_ready_nxt;
      r_req       <= w_req_nxt;
      r_buf_full  <= w_buf_full_nxt;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      // BIT_HI is held exactly while cnt < th, so the line follows the state.
      r_out       <= (r_state == S_BIT_HI);
      if (w_xfer && (r_state != S_WAIT_FIRST)) r_buf <= pix_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT_FIRST;
            r_busy  <= 1'b1;
            r_sent  <= '0;
          end
        end
        S_WAIT_FIRST: begin
          if (w_xfer) begin
            r_shift <= reorder(pix_data);
            r_sent  <= PIX_W'(1);
            r_bit   <= '0;
            r_cnt   <= '0;
            r_state <= S_BIT_HI;
          end
        end
        S_BIT_HI, S_BIT_LO: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_BIT_HI;
            if (r_bit != BIT_LAST) begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= r_shift << 1;
            end else if (w_finish) begin
              r_state <= S_LATCH;
              r_lat   <= '0;
            end else if (r_buf_full) begin
              r_shift <= reorder(r_buf);
              r_sent  <= r_sent + PIX_W'(1);
              r_bit   <= '0;
            end else begin
              r_underrun <= 1'b1;
              r_state    <= S_LATCH;
              r_lat      <= '0;
            end
          end else begin
            r_cnt   <= w_cnt_inc;
            r_state <= (w_cnt_inc < w_th) ? S_BIT_HI : S_BIT_LO;
          end
        end
        S_LATCH: begin
          if (r_lat == LAT_END) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready = r_pix_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign underrun  = r_underrun;
  assign out       = r_out;

endmodule

// File: tb/tb_neopix_chain.sv
// tb_neopix_chain: directed bench for neopix_chain (2 pixels, TBIT=16,
// T0H=4, T1H=12, TRES=20). Expected words follow NEOPIX_GRB_ORDER_EN.
module tb_neopix_chain;

  localparam int unsigned NP   = 2;
  localparam int unsigned BPP  = 24;
  localparam int unsigned T0H  = 4;
  localparam int unsigned T1H  = 12;
  localparam int unsigned TBIT = 16;
  localparam int unsigned TRES = 20;
  localparam int          FRAME_BITS = NP * BPP * TBIT;   // 768
  localparam int          MAXS = 2000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [BPP-1:0] pix_data;
  logic           pix_valid;
  logic           pix_ready;
  logic           busy;
  logic           done;
  logic           underrun;
  logic           out;

  always #5 clk = ~clk;

  neopix_chain #(
    .NUM_PIXELS(NP), .BITS_PER_PIXEL(BPP), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .done(done), .underrun(underrun), .out(out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic           samp [MAXS];
  logic [BPP-1:0] px   [NP];
  int  fr, done_t, und_t, done_cnt, und_cnt, extra;
  logic busy_at_done;
  logic cap_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BPP-1:0] exp_word(input logic [BPP-1:0] d);
`ifdef NEOPIX_GRB_ORDER_EN
    return {d[15:8], d[23:16], d[7:0]};
`else
    return d;
`endif
  endfunction

  function automatic int count_high(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < MAXS && samp[i] === 1'b1) n++;
    return n;
  endfunction

  // Rebuild pixel p from the captured line; malformed bit windows count as bad.
  task automatic decode(input int p, output logic [BPP-1:0] w, output int bad);
    w = '0;
    bad = 0;
    for (int b = 0; b < BPP; b++) begin
      int s, h;
      logic ok;
      s = fr + (p * BPP + b) * TBIT;
      h = count_high(s, s + TBIT - 1);
      ok = (fr >= 0) && ((h == T0H) || (h == T1H));
      for (int j = 0; j < TBIT; j++)
        if (s + j < 0 || s + j >= MAXS || samp[s + j] !== ((j < h) ? 1'b1 : 1'b0)) ok = 1'b0;
      if (!ok) bad++;
      w = {w[BPP-2:0], (h == T1H)};
    end
  endtask

  task automatic feed(input int n, input logic hold);
    for (int i = 0; i < n; i++) begin
      logic acc;
      acc = 1'b0;
      pix_data  = px[i];
      pix_valid = 1'b1;
      for (int c = 0; c < MAXS && !acc; c++) begin
        if (pix_ready) begin
          @(posedge clk);
          acc = 1'b1;
          #1;
        end else begin
          @(negedge clk);
        end
      end
      check("feed_accept", 32'(acc), 32'd1);
    end
    if (hold) begin
      pix_data  = 24'hDEAD77;
      pix_valid = 1'b1;
      for (int c = 0; c < MAXS && !cap_done; c++) begin
        @(negedge clk);
        if (pix_ready && !cap_done) extra++;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic capture(input int sp);
    fr = -1; done_t = -1; und_t = -1; done_cnt = 0; und_cnt = 0; busy_at_done = 1'b1;
    for (int t = 0; t < MAXS; t++) begin
      @(negedge clk);
      if (t == sp)     start = 1'b1;
      if (t == sp + 1) start = 1'b0;
      samp[t] = out;
      if (out === 1'b1 && fr < 0) fr = t;
      if (underrun) begin und_cnt++; if (und_t < 0) und_t = t; end
      if (done) begin
        done_cnt++;
        if (done_t < 0) begin done_t = t; busy_at_done = busy; end
      end
      if (done_t >= 0 && t >= done_t + 3) break;
    end
    check("done_pulse_count", 32'(done_cnt), 32'd1);
    check("busy_at_done", 32'(busy_at_done), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(pix_ready), 32'd1);
  endtask

  task automatic run_frame(input int n_feed, input logic hold, input int sp);
    do_start();
    cap_done = 1'b0;
    extra = 0;
    fork
      feed(n_feed, hold);
      begin capture(sp); cap_done = 1'b1; end
    join
  endtask

  // Checks shared by every complete two-pixel frame.
  task automatic check_full_frame(input string tag);
    logic [BPP-1:0] w;
    int bad;
    check({tag, "_first_rise"}, 32'(fr), 32'd1);
    for (int p = 0; p < NP; p++) begin
      decode(p, w, bad);
      check({tag, "_pixel"}, 32'(w), 32'(exp_word(px[p])));
      check({tag, "_bad_windows"}, 32'(bad), 32'd0);
    end
    check({tag, "_frame_len"}, 32'(done_t - fr), 32'(FRAME_BITS + TRES));
    check({tag, "_latch_high"}, 32'(count_high(fr + FRAME_BITS, done_t)), 32'd0);
    check({tag, "_underrun"}, 32'(und_cnt), 32'd0);
  endtask

  initial begin
    logic [BPP-1:0] w;
    int bad;
    logic [BPP-1:0] e0;
    start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: first bit 1 (12 high), second bit 0 (4 high) in verbatim order.
    px[0] = 24'hA50000; px[1] = 24'h000001;
    run_frame(2, 1'b0, -1);
    check_full_frame("basic");
    e0 = exp_word(px[0]);
    check("basic_bit0_high", 32'(count_high(fr, fr + 15)), e0[23] ? 32'(T1H) : 32'(T0H));
    check("basic_bit1_high", 32'(count_high(fr + 16, fr + 31)), e0[22] ? 32'(T1H) : 32'(T0H));
    repeat (3) @(negedge clk);

    // Ignored inputs: junk valid while idle, start mid-frame, valid held while not ready.
    pix_data = 24'hBADBAD; pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_low", 32'(pix_ready), 32'd0);
    px[0] = 24'h0F0F0F; px[1] = 24'hF0F0F0;
    run_frame(2, 1'b1, 200);
    check_full_frame("ignored");
    check("ignored_extra_xfer", 32'(extra), 32'd0);
    repeat (3) @(negedge clk);

    // Underrun: second pixel withheld.
    px[0] = 24'h5A5A5A; px[1] = 24'h0;
    run_frame(1, 1'b0, -1);
    check("und_count", 32'(und_cnt), 32'd1);
    check("und_time", 32'(und_t - (fr - 1)), 32'(BPP * TBIT));
    check("und_to_done", 32'(done_t - und_t), 32'(TRES + 1));
    check("und_latch_high", 32'(count_high(und_t, done_t)), 32'd0);
    decode(0, w, bad);
    check("und_pixel0", 32'(w), 32'(exp_word(px[0])));
    check("und_ready_after", 32'(pix_ready), 32'd0);
    check("und_busy_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Reset mid-frame forces outputs low asynchronously.
    px[0] = 24'hFFFFFF; px[1] = 24'hFFFFFF;
    do_start();
    cap_done = 1'b0;
    feed(2, 1'b0);
    repeat (98) @(negedge clk);
    check("pre_reset_out", 32'(out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(pix_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    px[0] = 24'h112233; px[1] = 24'hC3C3C3;
    run_frame(2, 1'b0, -1);
    check_full_frame("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neopix_chain.md
# neopix_chain

Parametrised WS2812-class serial LED driver that streams a frame of `NUM_PIXELS` pixels onto one single-wire output. It is the next generation of the team's single-pixel NEOPIX driver and adds:
- configurable pixel count, bit width and pulse timings;
- a valid/ready pixel input with a one-entry prefetch buffer, so bits are gapless;
- an explicit latch (reset) period, plus start/busy/done frame control and underrun detection.

It sits between a pixel source (frame buffer reader or pattern generator) and the LED strip pad.

## Interface
- `NUM_PIXELS`, 8, pixels per frame (≥1)
- `BITS_PER_PIXEL`, 24, bits per pixel (24 RGB, 32 RGBW)
- `T0H`, 4, high cycles for a 0 bit (≥1)
- `T1H`, 12, high cycles for a 1 bit (`T0H` < `T1H` < `TBIT`)
- `TBIT`, 16, total cycles per bit
- `TRES`, 800, low cycles of the latch period (≥1)

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle frame request; sampled only in IDLE
- `pix_data`  in  `BITS_PER_PIXEL`  pixel word, transmitted MSB first
- `pix_valid`  in  1  `pix_data` valid
- `pix_ready`  out  1  block can accept a pixel; transfer on `pix_valid && pix_ready`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse at the end of the latch period
- `underrun`  out  1  one-cycle pulse when the frame is aborted for lack of data
- `out`  out  1  registered serial line to the strip

## Operation
- States: IDLE, WAIT_FIRST, BIT_HI, BIT_LO, LATCH.
- **IDLE:** `out`=0, `busy`=0. `start`=1 → WAIT_FIRST; pixel and request counters clear.
- **WAIT_FIRST:** `pix_ready`=1 and `out`=0. Waits indefinitely for the first pixel. On transfer, the word loads directly into the shift register → BIT_HI with bit counter 0.
- **BIT_HI / BIT_LO:** cycle counter `cnt` runs 0..`TBIT`-1.
  - `out`=1 while `cnt` < th, where th = `T1H` if the current MSB is 1, else `T0H`; BIT_HI covers those cycles.
  - `out`=0 for the remaining cycles (BIT_LO).
  - At `cnt`=`TBIT`-1: shift left and increment the bit counter. The next bit starts on the following cycle with no gap.
- **Prefetch buffer (one entry):**
  - `pix_ready` = frame active && buffer empty && pixels requested < `NUM_PIXELS`.
  - `pix_ready` is also high in WAIT_FIRST.
- **Pixel boundary:** at the last cycle of the last bit of a pixel:
  - if pixels sent = `NUM_PIXELS` → LATCH;
  - else if buffer full → buffer moves to the shift register and the buffer empties in the same cycle;
  - else → `underrun` pulse, frame aborted → LATCH.
- **LATCH:** `out`=0 for exactly `TRES` cycles. Then `done` pulses for one cycle with `busy` dropping in the same cycle → IDLE.
- `start` outside IDLE is ignored. `pix_valid` while `pix_ready`=0 is ignored; data is not consumed.
- Counter widths are `$clog2` of their max+1. No arithmetic overflow is reachable with legal parameters.

## Timing
- Reset values: `out`=0, `pix_ready`=0, `busy`=0, `done`=0, `underrun`=0. State is IDLE and the buffer is empty.
- `rst_n` low mid-frame forces `out` low asynchronously. The partial frame is discarded and not resumed.
- `start` at edge k → `busy`=1 and `pix_ready`=1 after edge k.
- First transfer at edge m → `out` rises after edge m+1.
- Pixel duration is `BITS_PER_PIXEL`·`TBIT` cycles.
- Full frame from first `out` rise to `done` = `NUM_PIXELS`·`BITS_PER_PIXEL`·`TBIT` + `TRES` cycles.
- Buffer refill latency: `pix_ready` reasserts the cycle after the buffer→shift move. The source therefore has one pixel period, less one cycle, to supply each word.
- Simultaneous buffer refill and shift-register load in the same cycle is legal: the shift register takes the old buffer contents and the buffer takes the new word.

## Configuration
- `NEOPIX_GRB_ORDER_EN` defined: `pix_data` is interpreted as {R,G,B[,W]} bytes and transmitted in G,R,B[,W] order. The reordering is applied at load into the shift register.
- Macro undefined: `pix_data` is transmitted verbatim, MSB first.
- Timing, handshake and state behaviour are identical in both builds.

## Test plan
All scenarios use `NUM_PIXELS`=2, `TBIT`=16, `T0H`=4, `T1H`=12, `TRES`=20, with the macro off unless stated.
- **Basic frame:** pixels 24'hA50000 and 24'h000001, valid held high.
  - First bit high 12 cycles then low 4; second bit high 4 then low 12.
  - Total 768 cycles of bits, then 20 low cycles, then `done` for one cycle.
- **Gapless bits:** back-to-back pixels. No extra cycles between bit 23 of pixel 0 and bit 0 of pixel 1; the period measures exactly 16 at every bit.
- **Underrun:** second pixel withheld.
  - `underrun` pulses at cycle 384 of the frame; `out` stays 0 for 20 cycles.
  - `done` pulses once; `busy` then falls.
- **Ignored inputs:**
  - `start` pulsed mid-frame has no effect on frame length.
  - `pix_valid` with `pix_ready`=0 consumes nothing.
- **Reset mid-frame:** `rst_n` low at cycle 100. `out`, `busy` and `pix_ready` go 0 immediately; a fresh `start` runs a full correct frame.
- **GRB build:** with `NEOPIX_GRB_ORDER_EN` defined, pixel 24'h112233 is transmitted as the bit pattern of 24'h221133.
